// File: rtl/reg_sequencer.sv
// Control sequencer for the X/Y/Z datapath registers and the ULA: accepts one command,
// issues transfer codes over one or more cycles, then pulses done. Optional SEQ_QUEUE_EN
// adds a one-entry command buffer.
module reg_sequencer #(
    parameter int unsigned AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [AMT_W-1:0] amt,
    output logic             cmd_ready,
    output logic [2:0]       tx,
    output logic [2:0]       ty,
    output logic [2:0]       tz,
    output logic [1:0]       ula_sel,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StExec, StShift, StDone} state_e;

    localparam logic [2:0] XHold   = 3'b000;
    localparam logic [2:0] XLoad   = 3'b001;
    localparam logic [2:0] XShiftR = 3'b010;
    localparam logic [2:0] XShiftL = 3'b011;
    localparam logic [2:0] XReset  = 3'b100;

    localparam logic [1:0] UlaPass = 2'b00;
    localparam logic [1:0] UlaAdd  = 2'b01;
    localparam logic [1:0] UlaSub  = 2'b10;

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpLdx  = 3'b001;
    localparam logic [2:0] OpLdy  = 3'b010;
    localparam logic [2:0] OpAdd  = 3'b011;
    localparam logic [2:0] OpSub  = 3'b100;
    localparam logic [2:0] OpShrx = 3'b101;
    localparam logic [2:0] OpShlx = 3'b110;
    localparam logic [2:0] OpClr  = 3'b111;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] amt_q;
    logic [AMT_W-1:0] cnt_q;
    logic [2:0]       tx_q, ty_q, tz_q;
    logic [1:0]       ula_q;
    logic             busy_q;
    logic             done_q;

    logic             launch;
    logic [2:0]       launch_op;
    logic [AMT_W-1:0] launch_amt;
    logic [2:0]       step_tx, step_ty, step_tz;
    logic [1:0]       step_ula;
    logic             exec_more;

`ifdef SEQ_QUEUE_EN
    logic             buf_valid_q;
    logic [2:0]       buf_op_q;
    logic [AMT_W-1:0] buf_amt_q;
    logic             accept;

    // The buffer only fills outside IDLE, so in IDLE it is normally empty and ready stays high.
    assign cmd_ready  = !buf_valid_q;
    assign accept     = start && cmd_ready;
    assign launch_op  = buf_valid_q ? buf_op_q : opcode;
    assign launch_amt = buf_valid_q ? buf_amt_q : amt;
    assign launch     = ((state_q == StIdle) && (buf_valid_q || accept)) ||
                        ((state_q == StDone) && buf_valid_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_op_q    <= 3'b000;
            buf_amt_q   <= '0;
        end else if (launch && buf_valid_q) begin
            buf_valid_q <= 1'b0;
        end else if (accept && (state_q != StIdle)) begin
            buf_valid_q <= 1'b1;
            buf_op_q    <= opcode;
            buf_amt_q   <= amt;
        end
    end
`else
    assign cmd_ready  = (state_q == StIdle);
    assign launch     = (state_q == StIdle) && start;
    assign launch_op  = opcode;
    assign launch_amt = amt;
`endif

    // EXEC-cycle codes for the command about to start; shifts by zero degrade to HOLD.
    always_comb begin
        step_tx  = XHold;
        step_ty  = XHold;
        step_tz  = XHold;
        step_ula = UlaPass;
        case (launch_op)
            OpNop: ;
            OpLdx: step_tx = XLoad;
            OpLdy: step_ty = XLoad;
            OpAdd: begin
                step_ula = UlaAdd;
                step_tz  = XLoad;
            end
            OpSub: begin
                step_ula = UlaSub;
                step_tz  = XLoad;
            end
            OpShrx: if (launch_amt != '0) step_tx = XShiftR;
            OpShlx: if (launch_amt != '0) step_tx = XShiftL;
            OpClr: begin
                step_tx = XReset;
                step_ty = XReset;
                step_tz = XReset;
            end
            default: ;
        endcase
    end

    assign exec_more = ((op_q == OpShrx) || (op_q == OpShlx)) && (amt_q > AMT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 3'b000;
            amt_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= XHold;
            ty_q    <= XHold;
            tz_q    <= XHold;
            ula_q   <= UlaPass;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (launch) begin
            state_q <= StExec;
            op_q    <= launch_op;
            amt_q   <= launch_amt;
            cnt_q   <= launch_amt;
            tx_q    <= step_tx;
            ty_q    <= step_ty;
            tz_q    <= step_tz;
            ula_q   <= step_ula;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StExec: begin
                    if (exec_more) begin
                        // tx keeps its shift code; cnt counts shifts still to issue.
                        state_q <= StShift;
                        cnt_q   <= cnt_q - AMT_W'(1);
                    end else begin
                        state_q <= StDone;
                        tx_q    <= XHold;
                        ty_q    <= XHold;
                        tz_q    <= XHold;
                        ula_q   <= UlaPass;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StShift: begin
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= StDone;
                        tx_q    <= XHold;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - AMT_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx      = tx_q;
    assign ty      = ty_q;
    assign tz      = tz_q;
    assign ula_sel = ula_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/reg_sequencer.md
Name: reg_sequencer

Overview:
- Multi-cycle control unit for the CPU's three 4-bit datapath registers (X, Y, Z) and the ULA.
- Accepts one command (opcode plus shift amount) through a start/ready handshake.
- Sequences the 3-bit transfer codes tx/ty/tz and the ULA select over one or more cycles, then pulses done.
- Sits between the instruction source and the register/ULA datapath; it carries control only, never data.

Parameters:
- AMT_W, 2, width of the shift-amount field; maximum shift count is 2^AMT_W-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  command valid; accepted when start=1 and cmd_ready=1 at a rising edge
- opcode  input  3  command code, sampled on acceptance
- amt  input  AMT_W  shift count for SHRX/SHLX, sampled on acceptance
- cmd_ready  output  1  command can be accepted this cycle
- tx  output  3  transfer code to register X
- ty  output  3  transfer code to register Y
- tz  output  3  transfer code to register Z
- ula_sel  output  2  ULA operation: 00 PASS, 01 ADD, 10 SUB, 11 reserved/unused
- busy  output  1  high in EXEC and SHIFT
- done  output  1  one-cycle completion pulse

Behaviour:
- Transfer codes: HOLD=000, LOAD=001, SHIFTR=010, SHIFTL=011, RESET=100.
- Any register not named by the current step gets HOLD.
- tx/ty/tz/ula_sel are Moore outputs decoded from state and the latched command; the datapath registers act on the edge ending that cycle.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; latched opcode/amt/count=0; done=0; busy=0.
  - tx=ty=tz=HOLD; ula_sel=00; cmd_ready=1 once rst_n releases.
  - Reset mid-command aborts it: no further codes are issued and no done pulse follows.
- States:
  - IDLE: cmd_ready=1, all HOLD. On accept, latch opcode/amt and go to EXEC.
  - EXEC: busy=1, one cycle, step per opcode below. Next state is SHIFT for SHRX/SHLX with amt>1, else DONE.
  - SHIFT: busy=1. Repeats the shift code; count decrements per cycle; go to DONE when the count reaches 1.
  - DONE: done=1, all HOLD, busy=0, one cycle, then IDLE.
- Opcodes (EXEC step):
  - 000 NOP: all HOLD.
  - 001 LDX: tx=LOAD.
  - 010 LDY: ty=LOAD.
  - 011 ADD: ula_sel=01, tz=LOAD.
  - 100 SUB: ula_sel=10, tz=LOAD.
  - 101 SHRX: tx=SHIFTR.
  - 110 SHLX: tx=SHIFTL.
  - 111 CLR: tx=ty=tz=RESET.
- Shift ops issue exactly amt SHIFTR/SHIFTL cycles in total (EXEC plus SHIFT). amt=0 means the EXEC cycle issues HOLD instead of a shift, then DONE.
- Latency from accept edge to done high:
  - 2 cycles for non-shift ops and for shifts with amt<=1.
  - amt+1 cycles for shifts with amt>=2.
- Without the queue, start is ignored in EXEC/SHIFT/DONE; commands are not lost silently because cmd_ready=0 in those states.
- opcode/amt changes after acceptance have no effect.

Optional Feature:
- Macro: SEQ_QUEUE_EN.
- With the macro defined:
  - One-entry command buffer. While not IDLE, cmd_ready = buffer empty; start with cmd_ready=1 stores opcode/amt.
  - In DONE with a buffered command, the next state is EXEC directly (skipping IDLE) and the buffer empties. Back-to-back commands therefore run with one DONE cycle between them.
  - A start during DONE while the buffer is empty is stored and executes after the pending IDLE cycle.
  - Reset clears the buffer.
- Without the macro: no buffer; cmd_ready = (state==IDLE).

Test Plan:
- Reset: rst_n=0 mid-SHLX amt=3 after 1 shift → tx/ty/tz=000, busy=0, done never pulses; after release cmd_ready=1.
- LDX: start, opcode=001 → next cycle tx=001, ty=tz=000, busy=1; following cycle done=1; then IDLE.
- ADD: opcode=011 → EXEC cycle ula_sel=01, tz=001, tx=ty=000; SUB (100) gives ula_sel=10.
- SHRX amt=3 → tx=010 for exactly 3 consecutive cycles, done on the 4th cycle after accept; amt=0 → no 010 issued, done 2 cycles after accept.
- CLR during busy (no queue): start with opcode=111 while SHIFT is active → ignored, cmd_ready=0; issued later from IDLE → tx=ty=tz=100 for one cycle.
- SEQ_QUEUE_EN: LDY then CLR back-to-back while busy → cmd_ready drops after the second accept; sequence ty=001, DONE, tx=ty=tz=100, DONE; two done pulses.
